asrn: RTL and testbench
=======================

# asrn

Parametrised addressable shift register: successor to the fixed 8-stage tap register, generalised in width and depth. Each enabled clock shifts `din` into stage 0 and moves every stage one position deeper. Any stage can be read through `addr`. A fill counter tracks how many stages hold real samples, so the tap output carries a validity flag. It sits in the datapath as a delay line or sample history buffer with a selectable delay.

## Interface
Parameters:
- `N`, default 8: data width in bits.
- `DEPTH`, default 8: number of stages; legal range is 2 to 256.
- `AW`, default 3: address width; the instantiator must set it so that 2^AW >= DEPTH.

Ports:
- `clk`  input  1: clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `en`  input  1: shift enable; a shift occurs on a rising edge with `en`=1.
- `din`  input  N: sample shifted into stage 0.
- `addr`  input  AW: tap select; stage index 0 (newest) to DEPTH-1 (oldest).
- `dout`  output  N: contents of stage `addr`.
- `dout_valid`  output  1: the addressed stage holds a sample written since reset.
- `fill`  output  AW+1: number of valid stages, 0 to DEPTH.
- `full`  output  1: asserted when `fill` == DEPTH.

## Operation
- Storage is DEPTH registers of N bits each: stage[0] to stage[DEPTH-1].
- Shift (`en`=1, `rst`=0):
  - stage[0] <= `din`.
  - stage[i] <= stage[i-1] for 1 <= i < DEPTH.
  - The value in stage[DEPTH-1] is discarded.
- Hold (`en`=0): all stages and `fill` keep their values.
- Fill counter:
  - Increments by 1 on every shift while below DEPTH.
  - Saturates at DEPTH; never wraps.
  - Only `rst` decreases it.
- Read path:
  - `dout` = stage[`addr`].
  - `dout_valid` = (`addr` < `fill`).
- Out-of-range address (`addr` >= DEPTH, possible when DEPTH is not a power of two): `dout` = 0 and `dout_valid` = 0. The read must never select an undefined stage.
- Reset:
  - All stages go to 0, `fill` to 0, `full` to 0. `dout` = 0 and `dout_valid` = 0 after the reset edge.
  - `rst` takes priority over `en` on the same edge.
  - Reset in the middle of a sequence discards all history. The next shift starts again with `fill` = 1.
- `addr` may change on any cycle. It is not sampled by the shift logic.

## Timing
- A sample written at enabled edge E appears at stage j after j further enabled edges. It is therefore readable at `addr`=j once E and j more enabled edges have occurred. Disabled cycles do not age samples.
- Default (combinational read): `dout` and `dout_valid` follow `addr` in the same cycle, and follow a shift immediately after the edge.
- `fill` and `full` are registered. They update on the same edge as the shift.

## Configuration
- Macro: `ASRN_REGOUT_EN`.
- Defined: `dout` and `dout_valid` are registered. They are sampled every clock, independent of `en`, from the current `addr` and stage contents, which adds exactly one cycle of latency relative to the default. Reset clears both registers to 0 on the reset edge. `fill` and `full` timing is unchanged.
- Undefined: combinational read path, zero added latency.

## Test plan
All scenarios use N=8 and DEPTH=8 unless stated otherwise.
- Reset, then `en`=1 with `din` = 1, 2, 4, 8, 16, 32, 64 on seven edges and `addr`=6 -> `dout`=1, `dout_valid`=1, `fill`=7, `full`=0. `addr`=7 -> `dout_valid`=0.
- Continue with `din`=128 and then 0xAA -> after 128: `addr`=7 gives 1, `full`=1. After 0xAA: `addr`=7 gives 2, `addr`=0 gives 0xAA, `fill` stays at 8.
- `en`=0 for 5 cycles while `din` toggles -> stage contents and `fill` unchanged; `dout` at `addr`=3 stays constant.
- Assert `rst` while `en`=1 on a full register -> every `addr` reads `dout`=0 with `dout_valid`=0, and `fill`=0. One further shift of 0x55 -> `fill`=1, `addr`=0 gives 0x55.
- DEPTH=6, AW=3: fill completely, then `addr`=6 and `addr`=7 -> `dout`=0, `dout_valid`=0. `addr`=5 returns the oldest sample.
- With `ASRN_REGOUT_EN` defined, repeat the first scenario -> identical values, each appearing exactly one clock later than in the default build.

Source files
------------

// File: rtl/asrn.sv
// asrn: parametrised addressable shift register with a fill counter and tap validity flag.
// Define ASRN_REGOUT_EN to register dout/dout_valid (one extra cycle of read latency).
module asrn #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  din,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    output logic [AW:0]   fill,
    output logic          full
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [N-1:0] stage_q [DEPTH];
    logic [N-1:0] stage_d [DEPTH];
    logic [AW:0]  fill_q;
    logic [AW:0]  fill_d;
    logic         full_q;
    logic         full_d;
    logic [N-1:0] rd_data_s;
    logic         rd_valid_s;

    // Next-state: shift on enable, fill counter saturates at DEPTH
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q < DEPTH_C) begin
                fill_d = fill_q + {{AW{1'b0}}, 1'b1};
            end else begin
                fill_d = fill_q;
            end
        end else begin
            stage_d = stage_q;
            fill_d  = fill_q;
        end
        full_d = (fill_d == DEPTH_C);
    end

    // State registers with synchronous reset taking priority over shift
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
        end
    end

    // Tap mux: only a matching in-range stage can drive the read, so addr >= DEPTH reads 0/invalid
    always_comb begin
        rd_data_s  = '0;
        rd_valid_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, addr} == (AW+1)'(i)) begin
                rd_data_s  = stage_q[i];
                rd_valid_s = ({1'b0, addr} < fill_q);
            end
        end
    end

`ifdef ASRN_REGOUT_EN
    logic [N-1:0] dout_q;
    logic [N-1:0] dout_d;
    logic         dout_valid_q;
    logic         dout_valid_d;

    // Registered read path samples every clock regardless of en
    always_comb begin
        dout_d       = rd_data_s;
        dout_valid_d = rd_valid_s;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`else
    assign dout       = rd_data_s;
    assign dout_valid = rd_valid_s;
`endif

    assign fill = fill_q;
    assign full = full_q;
endmodule

// File: tb/tb_asrn.sv
// Self-checking bench for asrn: DEPTH=8 and DEPTH=6 instances against a queue-based history model.
module tb_asrn;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [2:0] addr8;
    logic [2:0] addr6;
    logic [7:0] dout8;
    logic [7:0] dout6;
    logic       v8;
    logic       v6;
    logic [3:0] fill8;
    logic [3:0] fill6;
    logic       full8;
    logic       full6;

    int n_cmp = 0;
    int n_bad = 0;

    // Sample history, newest first; length is the number of valid stages
    logic [7:0] h8[$];
    logic [7:0] h6[$];
    // Expected registered-read outputs (used when the registered build is selected)
    logic [7:0] r8_d = 8'h00;
    logic [7:0] r6_d = 8'h00;
    logic       r8_v = 1'b0;
    logic       r6_v = 1'b0;

    always #5 clk = ~clk;

    asrn #(.N(8), .DEPTH(8), .AW(3)) u8 (
        .clk(clk), .rst(rst), .en(en), .din(din), .addr(addr8),
        .dout(dout8), .dout_valid(v8), .fill(fill8), .full(full8)
    );

    asrn #(.N(8), .DEPTH(6), .AW(3)) u6 (
        .clk(clk), .rst(rst), .en(en), .din(din), .addr(addr6),
        .dout(dout6), .dout_valid(v6), .fill(fill6), .full(full6)
    );

    function automatic logic [7:0] hist_data(input logic [7:0] h[$], input int a);
        if (a < h.size()) return h[a];
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] d, input int a8, input int a6);
        logic [7:0] p8;
        logic [7:0] p6;
        logic       pv8;
        logic       pv6;
        rst   = r;
        en    = e;
        din   = d;
        addr8 = 3'(a8);
        addr6 = 3'(a6);
        p8  = hist_data(h8, a8);
        p6  = hist_data(h6, a6);
        pv8 = (a8 < h8.size());
        pv6 = (a6 < h6.size());
        @(posedge clk);
        if (r) begin
            h8.delete();
            h6.delete();
            r8_d = 8'h00; r8_v = 1'b0;
            r6_d = 8'h00; r6_v = 1'b0;
        end else begin
            r8_d = p8; r8_v = pv8;
            r6_d = p6; r6_v = pv6;
            if (e) begin
                h8.push_front(d);
                if (h8.size() > 8) void'(h8.pop_back());
                h6.push_front(d);
                if (h6.size() > 6) void'(h6.pop_back());
            end
        end
        #1;
`ifdef ASRN_REGOUT_EN
        chk("dout8", {24'h0, dout8}, {24'h0, r8_d});
        chk("valid8", {31'h0, v8}, {31'h0, r8_v});
        chk("dout6", {24'h0, dout6}, {24'h0, r6_d});
        chk("valid6", {31'h0, v6}, {31'h0, r6_v});
`else
        chk("dout8", {24'h0, dout8}, {24'h0, hist_data(h8, a8)});
        chk("valid8", {31'h0, v8}, (a8 < h8.size()) ? 32'd1 : 32'd0);
        chk("dout6", {24'h0, dout6}, {24'h0, hist_data(h6, a6)});
        chk("valid6", {31'h0, v6}, (a6 < h6.size()) ? 32'd1 : 32'd0);
`endif
        chk("fill8", {28'h0, fill8}, h8.size());
        chk("full8", {31'h0, full8}, (h8.size() == 8) ? 32'd1 : 32'd0);
        chk("fill6", {28'h0, fill6}, h6.size());
        chk("full6", {31'h0, full6}, (h6.size() == 6) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 8'h00; addr8 = 3'd0; addr6 = 3'd0;
        // Reset, with en high to show reset priority
        step(1'b1, 1'b1, 8'hFF, 0, 0);
        step(1'b1, 1'b0, 8'h00, 3, 3);
        // Seven powers of two, reading tap 6
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(1 << i), 6, 6);
        step(1'b0, 1'b0, 8'h00, 6, 6);
        chk("tp1_dout_addr6", {24'h0, dout8}, 32'h01);
        chk("tp1_fill", {28'h0, fill8}, 32'd7);
        step(1'b0, 1'b0, 8'h00, 7, 7);
        step(1'b0, 1'b0, 8'h00, 7, 7);
        chk("tp1_valid_addr7", {31'h0, v8}, 32'd0);
        // Fill to saturation then one more
        step(1'b0, 1'b1, 8'h80, 7, 7);
        chk("tp2_full", {31'h0, full8}, 32'd1);
        step(1'b0, 1'b1, 8'hAA, 7, 5);
        step(1'b0, 1'b0, 8'h00, 7, 5);
        step(1'b0, 1'b0, 8'h00, 0, 5);
        step(1'b0, 1'b0, 8'h00, 0, 5);
        chk("tp2_dout_addr0", {24'h0, dout8}, 32'hAA);
        chk("tp2_fill_sat", {28'h0, fill8}, 32'd8);
        // Hold with toggling din
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 8'h5A : 8'hA5, 3, 3);
        // Out-of-range taps on the DEPTH=6 instance
        step(1'b0, 1'b0, 8'h00, 7, 6);
        step(1'b0, 1'b0, 8'h00, 7, 7);
        step(1'b0, 1'b0, 8'h00, 7, 7);
        chk("d6_oob_valid", {31'h0, v6}, 32'd0);
        chk("d6_oob_dout", {24'h0, dout6}, 32'h00);
        step(1'b0, 1'b0, 8'h00, 5, 5);
        step(1'b0, 1'b0, 8'h00, 5, 5);
        // Reset on a full register with en high, then read all taps
        step(1'b1, 1'b1, 8'h77, 0, 0);
        chk("rst_fill", {28'h0, fill8}, 32'd0);
        for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 8'h00, a, a);
        step(1'b0, 1'b1, 8'h55, 0, 0);
        chk("rst_refill", {28'h0, fill8}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 0, 0);
        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 47) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
